enc_filter: RTL and testbench

ENC_FILTER -- requirements
Module: enc_filter

---
 rtl/enc_filter_if.sv | 27 ++
 rtl/enc_filter.sv | 131 +++++++++++++
 tb/tb_enc_filter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/enc_filter_if.sv
// Encoder filter signal bundle: raw encoder pins in, filtered/decoded quadrature out.
// Latency: none; this is wiring only.
// Backpressure: none; all signals are level or single-cycle pulse, no handshake.
interface enc_filter_if;
   logic       ENC_A_raw;
   logic       ENC_B_raw;
   logic       clear_err;
   logic       enc_a;
   logic       enc_b;
   logic       valid;
   logic       step;
   logic       dir;
   logic       err;
   logic [7:0] err_count;

   // Stimulus side: drives the raw pins and the error clear, observes results
   modport master (
      output ENC_A_raw, ENC_B_raw, clear_err,
      input  enc_a, enc_b, valid, step, dir, err, err_count
   );

   // Filter side
   modport slave (
      input  ENC_A_raw, ENC_B_raw, clear_err,
      output enc_a, enc_b, valid, step, dir, err, err_count
   );
endinterface

// File: rtl/enc_filter.sv
// Quadrature encoder front end: synchronise, glitch-filter each channel, decode steps/direction/errors.
// Latency: raw level reaches enc_a/enc_b after SYNC_STAGES+FILT_CYCLES edges; step/err one edge later.
// Backpressure: none; free-running, outputs are levels and single-cycle pulses.
module enc_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   enc_filter_if.slave bus
);
   localparam int CW     = $clog2(FILT_CYCLES + 1);
   localparam int SETTLE = SYNC_STAGES + FILT_CYCLES + 1;
   localparam int SW     = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] FILT_LAST   = CW'(FILT_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_a, sync_b;
   logic [1:0]             samp;       // {A,B} last synchroniser stage
   logic [1:0]             filt;       // {A,B} accepted levels
   logic [CW-1:0]          cnt [2];    // index 1 = A, 0 = B
   logic [SW-1:0]          settle, settle_nxt;
   logic [1:0]             prev_pair, prev_nxt;
   logic                   step_q, step_nxt;
   logic                   err_q, err_nxt;
   logic                   dir_q, dir_nxt;
   logic [7:0]             err_cnt, err_cnt_nxt;

   assign samp = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

   // Bring both raw channels into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[SYNC_STAGES-2:0], bus.ENC_A_raw};
         sync_b <= {sync_b[SYNC_STAGES-2:0], bus.ENC_B_raw};
      end
   end

   // Per-channel persistence filter: accept a new level only after FILT_CYCLES differing samples in a row
   always_ff @(posedge clk) begin
      if (rst) begin
         filt <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (samp[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == FILT_LAST) begin
               filt[i] <= samp[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // FSM and decoder registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         settle    <= '0;
         prev_pair <= '0;
         step_q    <= 1'b0;
         err_q     <= 1'b0;
         dir_q     <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         settle    <= settle_nxt;
         prev_pair <= prev_nxt;
         step_q    <= step_nxt;
         err_q     <= err_nxt;
         dir_q     <= dir_nxt;
         err_cnt   <= err_cnt_nxt;
      end
   end

   // Settle timing in INIT; in RUN classify each pair change as step, error or nothing
   always_comb begin
      state_nxt   = state;
      settle_nxt  = settle;
      prev_nxt    = prev_pair;
      step_nxt    = 1'b0;
      err_nxt     = 1'b0;
      dir_nxt     = dir_q;
      err_cnt_nxt = err_cnt;
      case (state)
         INIT: begin
            settle_nxt = settle + 1'b1;
            if (settle == SETTLE_LAST) begin
               state_nxt  = RUN;
               settle_nxt = '0;
               prev_nxt   = filt;
            end
         end
         RUN: begin
            prev_nxt = filt;
            case (filt ^ prev_pair)
               2'b01, 2'b10: begin
                  step_nxt = 1'b1;
                  // Forward (00->10->11->01) iff new A differs from old B
                  dir_nxt  = filt[1] ^ prev_pair[0];
               end
               2'b11: begin
                  err_nxt = 1'b1;
                  if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
               end
               default: ;
            endcase
         end
         default: state_nxt = INIT;
      endcase
      // Clear wins over a coincident increment; the err pulse itself is untouched
      if (bus.clear_err) err_cnt_nxt = '0;
   end

   assign bus.enc_a     = filt[1];
   assign bus.enc_b     = filt[0];
   assign bus.valid     = (state == RUN);
   assign bus.step      = step_q;
   assign bus.err       = err_q;
   assign bus.dir       = dir_q;
   assign bus.err_count = err_cnt;
endmodule

// File: tb/tb_enc_filter.sv
// Directed self-checking bench for enc_filter with SYNC_STAGES=2, FILT_CYCLES=4.
// Latency: expects filtered edges 6 edges after a raw change, step/err on the 7th.
// Backpressure: none; stimulus is free-running raw levels.
module tb_enc_filter;
   logic       clk = 1'b0;
   logic       rst;
   int         n_vec  = 0;
   int         n_mis  = 0;
   int         n_step = 0;
   int         n_err  = 0;
   logic [1:0] pair_m;

   enc_filter_if bus ();

   enc_filter #(.SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.step === 1'b1) n_step++;
      if (bus.err === 1'b1) n_err++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Apply a one-bit raw change and check latency, step pulse and direction
   task automatic move(input logic [1:0] p, input logic exp_dir, input string tag);
      logic [1:0] old;
      old = pair_m;
      bus.ENC_A_raw = p[1];
      bus.ENC_B_raw = p[0];
      tick(5);
      chk({tag, " hold"}, {30'd0, bus.enc_a, bus.enc_b}, {30'd0, old});
      tick(1);
      chk({tag, " lat"}, {30'd0, bus.enc_a, bus.enc_b}, {30'd0, p});
      chk({tag, " early step"}, {31'd0, bus.step}, 32'd0);
      tick(1);
      chk({tag, " step"}, {31'd0, bus.step}, 32'd1);
      chk({tag, " dir"}, {31'd0, bus.dir}, {31'd0, exp_dir});
      chk({tag, " err"}, {31'd0, bus.err}, 32'd0);
      tick(3);
      pair_m = p;
   endtask

   initial begin
      int s0;
      int e0;
      rst           = 1'b1;
      bus.ENC_A_raw = 1'b0;
      bus.ENC_B_raw = 1'b0;
      bus.clear_err = 1'b0;
      pair_m        = 2'b00;
      tick(3);
      chk("rst enc", {30'd0, bus.enc_a, bus.enc_b}, 32'd0);
      chk("rst valid", {31'd0, bus.valid}, 32'd0);
      chk("rst step", {31'd0, bus.step}, 32'd0);
      chk("rst err", {31'd0, bus.err}, 32'd0);
      chk("rst dir", {31'd0, bus.dir}, 32'd0);
      chk("rst errcnt", {24'd0, bus.err_count}, 32'd0);

      // Settle: valid on the 7th edge after release
      rst = 1'b0;
      tick(6);
      chk("settle valid6", {31'd0, bus.valid}, 32'd0);
      tick(1);
      chk("settle valid7", {31'd0, bus.valid}, 32'd1);
      chk("settle enc", {30'd0, bus.enc_a, bus.enc_b}, 32'd0);
      chk("settle steps", n_step, 32'd0);
      chk("settle errs", n_err, 32'd0);

      // Forward sequence
      s0 = n_step;
      move(2'b10, 1'b1, "fwd 00-10");
      move(2'b11, 1'b1, "fwd 10-11");
      move(2'b01, 1'b1, "fwd 11-01");
      move(2'b00, 1'b1, "fwd 01-00");
      chk("fwd steps", n_step - s0, 32'd4);
      chk("fwd errcnt", {24'd0, bus.err_count}, 32'd0);

      // Reverse sequence
      s0 = n_step;
      move(2'b01, 1'b0, "rev 00-01");
      move(2'b11, 1'b0, "rev 01-11");
      move(2'b10, 1'b0, "rev 11-10");
      move(2'b00, 1'b0, "rev 10-00");
      chk("rev steps", n_step - s0, 32'd4);
      chk("rev dir held", {31'd0, bus.dir}, 32'd0);

      // 3-cycle glitch on A is rejected
      s0 = n_step;
      bus.ENC_A_raw = 1'b1;
      tick(3);
      bus.ENC_A_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         chk("glitch3 enc_a", {31'd0, bus.enc_a}, 32'd0);
      end
      chk("glitch3 steps", n_step - s0, 32'd0);

      // 5-cycle pulse on A passes: rise (forward) then fall (reverse)
      s0 = n_step;
      bus.ENC_A_raw = 1'b1;
      tick(5);
      bus.ENC_A_raw = 1'b0;
      tick(1);
      chk("pulse5 rise", {31'd0, bus.enc_a}, 32'd1);
      tick(1);
      chk("pulse5 step", {31'd0, bus.step}, 32'd1);
      chk("pulse5 dir", {31'd0, bus.dir}, 32'd1);
      tick(15);
      chk("pulse5 fall", {31'd0, bus.enc_a}, 32'd0);
      chk("pulse5 steps", n_step - s0, 32'd2);
      chk("pulse5 dir end", {31'd0, bus.dir}, 32'd0);

      // Simultaneous changes are errors; count saturates
      s0 = n_step;
      e0 = n_err;
      bus.ENC_A_raw = 1'b1;
      bus.ENC_B_raw = 1'b1;
      tick(6);
      chk("err1 enc", {30'd0, bus.enc_a, bus.enc_b}, 32'd3);
      chk("err1 early", {31'd0, bus.err}, 32'd0);
      tick(1);
      chk("err1 pulse", {31'd0, bus.err}, 32'd1);
      chk("err1 step", {31'd0, bus.step}, 32'd0);
      chk("err1 count", {24'd0, bus.err_count}, 32'd1);
      chk("err1 dir", {31'd0, bus.dir}, 32'd0);
      tick(1);
      chk("err1 one cycle", {31'd0, bus.err}, 32'd0);
      bus.ENC_A_raw = 1'b0;
      bus.ENC_B_raw = 1'b0;
      tick(7);
      chk("err2 pulse", {31'd0, bus.err}, 32'd1);
      chk("err2 count", {24'd0, bus.err_count}, 32'd2);
      tick(1);
      for (int r = 1; r < 256; r++) begin
         bus.ENC_A_raw = 1'b1;
         bus.ENC_B_raw = 1'b1;
         tick(8);
         bus.ENC_A_raw = 1'b0;
         bus.ENC_B_raw = 1'b0;
         tick(8);
      end
      chk("sat count", {24'd0, bus.err_count}, 32'd255);
      chk("sat pulses", n_err - e0, 32'd512);
      chk("sat steps", n_step - s0, 32'd0);
      chk("sat dir", {31'd0, bus.dir}, 32'd0);

      // clear_err alone, then coincident with an err pulse
      bus.clear_err = 1'b1;
      tick(1);
      bus.clear_err = 1'b0;
      chk("clear count", {24'd0, bus.err_count}, 32'd0);
      bus.ENC_A_raw = 1'b1;
      bus.ENC_B_raw = 1'b1;
      tick(6);
      bus.clear_err = 1'b1;
      tick(1);
      bus.clear_err = 1'b0;
      chk("clear coinc err", {31'd0, bus.err}, 32'd1);
      chk("clear coinc count", {24'd0, bus.err_count}, 32'd0);
      tick(1);
      chk("clear after", {24'd0, bus.err_count}, 32'd0);
      tick(3);
      pair_m = 2'b11;

      // Leave dir=1 at 11, then reset mid-run
      move(2'b10, 1'b0, "pre 11-10");
      move(2'b11, 1'b1, "pre 10-11");
      s0 = n_step;
      e0 = n_err;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("mid rst enc", {30'd0, bus.enc_a, bus.enc_b}, 32'd0);
      chk("mid rst valid", {31'd0, bus.valid}, 32'd0);
      chk("mid rst dir", {31'd0, bus.dir}, 32'd0);
      chk("mid rst step", {31'd0, bus.step}, 32'd0);
      chk("mid rst err", {31'd0, bus.err}, 32'd0);
      tick(5);
      chk("mid rst enc5", {30'd0, bus.enc_a, bus.enc_b}, 32'd0);
      tick(1);
      chk("mid rst enc6", {30'd0, bus.enc_a, bus.enc_b}, 32'd3);
      chk("mid rst valid6", {31'd0, bus.valid}, 32'd0);
      tick(1);
      chk("mid rst valid7", {31'd0, bus.valid}, 32'd1);
      tick(3);
      chk("mid rst errcnt", {24'd0, bus.err_count}, 32'd0);
      chk("mid rst errs", n_err - e0, 32'd0);
      chk("mid rst steps", n_step - s0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
